led_pattern_gen: RTL



---
 rtl/led_pattern_pkg.sv | 24 ++
 rtl/led_pattern_gen_button_debounce.sv | 62 ++++++
 rtl/led_pattern_gen.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/led_pattern_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_pattern_pkg
// Description : Mode encoding shared by the LED pattern generator blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package led_pattern_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_COUNT   = 2'd0,
    MODE_SCAN    = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_BLINK   = 2'd3
  } mode_e;

  // Modes cycle in encoding order; BLINK wraps back to COUNT.
  function automatic mode_e next_mode(input mode_e m);
    return mode_e'(m + 2'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_pattern_gen_button_debounce.sv
`default_nettype none
// ============================================================================
// Module      : button_debounce
// Description : Two-flop synchroniser plus stability counter for a raw
//               push-button; reports the accepted level and its rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_level,
  output logic o_rise
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_a;
  logic             sync_b;
  logic [CNT_W-1:0] stable_cnt;
  logic             level;
  logic             rise;

  // Bring the asynchronous pin into the clock domain.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= i_btn;
      sync_b <= sync_a;
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES samples in a row.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      stable_cnt <= '0;
      level      <= 1'b0;
      rise       <= 1'b0;
    end else begin
      rise <= 1'b0;
      if (sync_b == level) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CNT_LAST) begin
        stable_cnt <= '0;
        level      <= sync_b;
        rise       <= sync_b;
      end else begin
        stable_cnt <= stable_cnt + CNT_W'(1);
      end
    end
  end

  assign o_level = level;
  assign o_rise  = rise;

endmodule
`default_nettype wire

// File: rtl/led_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : led_pattern_gen
// Description : Prescaled LED pattern generator with four button-selected
//               patterns (count, bounce scan, PWM breathe, blink-all).
// Revision    : 1.0 - initial release
// ============================================================================
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int NUM_LEDS        = 8,
  parameter int PRESCALE_BITS   = 20,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int PWM_BITS        = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_run,
  input  logic                i_mode_btn,
  output logic [NUM_LEDS-1:0] o_led,
  output logic [MODE_W-1:0]   o_mode,
  output logic                o_tick
);

  localparam int                POS_W    = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam logic [POS_W-1:0]    POS_LAST = POS_W'(NUM_LEDS - 1);
  localparam logic [PWM_BITS-1:0] DUTY_TOP = '1;

  logic [PRESCALE_BITS-1:0] prescale;
  logic                     wrap;
  mode_e                    mode;
  logic [NUM_LEDS-1:0]      count;
  logic [POS_W-1:0]         pos;
  logic [POS_W-1:0]         pos_next;
  logic                     pos_down;
  logic                     pos_down_next;
  logic [PWM_BITS-1:0]      duty;
  logic [PWM_BITS-1:0]      duty_next;
  logic                     duty_down;
  logic                     duty_down_next;
  logic [PWM_BITS-1:0]      pwm_cnt;
  logic                     toggle;
  logic [NUM_LEDS-1:0]      led_next;
  logic [NUM_LEDS-1:0]      led;
  logic                     tick_q;
  logic                     btn_level;
  logic                     btn_rise;
  logic                     mode_step;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_button_debounce (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_btn  (i_mode_btn),
    .o_level(btn_level),
    .o_rise (btn_rise)
  );

  // A press is a rising edge of the accepted (high) button level.
  assign mode_step = btn_rise & btn_level;

  // The pattern advances on the wrap itself; o_tick is its registered echo.
  assign wrap = i_run & (&prescale);

  // Free-running prescaler, frozen while not running.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      prescale <= '0;
    end else if (i_run) begin
      prescale <= prescale + PRESCALE_BITS'(1);
    end
  end

  // Scan position bounces between the ends without repeating an end position.
  if (NUM_LEDS == 1) begin : g_scan_single
    assign pos_next      = '0;
    assign pos_down_next = 1'b0;
  end else begin : g_scan_multi
    always_comb begin
      pos_next      = pos;
      pos_down_next = pos_down;
      if (pos_down) begin
        pos_next = pos - POS_W'(1);
        if (pos_next == '0) begin
          pos_down_next = 1'b0;
        end
      end else begin
        pos_next = pos + POS_W'(1);
        if (pos_next == POS_LAST) begin
          pos_down_next = 1'b1;
        end
      end
    end
  end

  // Breathe duty ramps up to full scale and back down to zero.
  always_comb begin
    duty_next      = duty;
    duty_down_next = duty_down;
    if (duty_down) begin
      duty_next = duty - PWM_BITS'(1);
      if (duty_next == '0) begin
        duty_down_next = 1'b0;
      end
    end else begin
      duty_next = duty + PWM_BITS'(1);
      if (duty_next == DUTY_TOP) begin
        duty_down_next = 1'b1;
      end
    end
  end

  // Mode register and pattern state; a mode change wins over a coincident tick.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      mode      <= MODE_COUNT;
      count     <= '0;
      pos       <= '0;
      pos_down  <= 1'b0;
      duty      <= '0;
      duty_down <= 1'b0;
      toggle    <= 1'b0;
    end else if (mode_step) begin
      mode      <= next_mode(mode);
      count     <= '0;
      pos       <= '0;
      pos_down  <= 1'b0;
      duty      <= '0;
      duty_down <= 1'b0;
      toggle    <= 1'b0;
    end else if (wrap) begin
      case (mode)
        MODE_COUNT: count <= count + NUM_LEDS'(1);
        MODE_SCAN: begin
          pos      <= pos_next;
          pos_down <= pos_down_next;
        end
        MODE_BREATHE: begin
          duty      <= duty_next;
          duty_down <= duty_down_next;
        end
        MODE_BLINK: toggle <= ~toggle;
        default: ;
      endcase
    end
  end

  // PWM counter runs every cycle regardless of i_run.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
  end

  // Map the current pattern state to LED levels.
  always_comb begin
    led_next = '0;
    case (mode)
      MODE_COUNT:   led_next = count;
      MODE_SCAN:    led_next = NUM_LEDS'(1) << pos;
      MODE_BREATHE: led_next = {NUM_LEDS{pwm_cnt < duty}};
      MODE_BLINK:   led_next = {NUM_LEDS{toggle}};
      default:      led_next = '0;
    endcase
  end

  // Registered LED drive and tick pulse.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      led    <= '0;
      tick_q <= 1'b0;
    end else begin
      led    <= led_next;
      tick_q <= wrap;
    end
  end

  assign o_led  = led;
  assign o_mode = mode;
  assign o_tick = tick_q;

endmodule
`default_nettype wire
